// File: rtl/umi_buffer.sv
// umi_buffer: synchronous valid/ready FIFO placed directly downstream of the
// UMI mux. It absorbs the granted packet and isolates mux arbitration from
// consumer backpressure. umi_in_ready is derived from registered pointer state
// only, so there is no combinational path from umi_out_ready to umi_in_ready.
//
// Optional build macro: UMI_BUFFER_BYPASS_EN
//   When defined, a packet offered while the buffer is empty is presented on
//   the output in the same cycle. If the consumer takes it, it is never
//   written to storage. If the consumer stalls, it is stored as a normal push.
module umi_buffer #(
  parameter int unsigned UW    = 256,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     flush,
  input  logic                     umi_in_valid,
  input  logic [UW-1:0]            umi_in_packet,
  output logic                     umi_in_ready,
  output logic                     umi_out_valid,
  output logic [UW-1:0]            umi_out_packet,
  input  logic                     umi_out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic [UW-1:0]  r_mem [DEPTH];

  logic           w_empty;
  logic           w_full;
  logic           w_stored_valid;
  logic           w_push;
  logic           w_pop;
  logic [UW-1:0]  w_head;

  assign w_empty        = (r_wr_ptr == r_rd_ptr);
  assign w_full         = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &
                          (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign fifo_count     = r_wr_ptr - r_rd_ptr;
  assign fifo_full      = w_full;
  assign fifo_empty     = w_empty;
  assign w_head         = r_mem[r_rd_ptr[AW-1:0]];

  // A stored entry is only offered when no flush is pending.
  assign w_stored_valid = ~w_empty & ~flush;
  assign umi_in_ready   = ~w_full & ~flush;

  // Pops only ever retire stored entries; a cut-through packet never moves
  // the read pointer.
  assign w_pop          = w_stored_valid & umi_out_ready;

`ifdef UMI_BUFFER_BYPASS_EN
  logic w_bypass;
  logic w_bypass_take;

  // Cut-through is offered only when nothing is stored, so ordering is kept.
  // It is suppressed during reset so nothing is seen downstream then.
  assign w_bypass       = w_empty & ~flush & umi_in_valid & nreset;
  assign w_bypass_take  = w_bypass & umi_out_ready;
  assign umi_out_valid  = w_stored_valid | w_bypass;
  assign umi_out_packet = w_bypass       ? umi_in_packet :
                          w_stored_valid ? w_head        : '0;
  assign w_push         = umi_in_valid & umi_in_ready & ~w_bypass_take;
`else
  assign umi_out_valid  = w_stored_valid;
  assign umi_out_packet = w_stored_valid ? w_head : '0;
  assign w_push         = umi_in_valid & umi_in_ready;
`endif

  // Pointer update: flush discards everything and wins over push/pop.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= umi_in_packet;
  end

endmodule

// File: tb/tb_umi_buffer.sv
// Self-checking bench for umi_buffer (DEPTH=4). A queue model acts as the
// scoreboard: packets are pushed when the bench drives an accepted input and
// popped and compared when the output is consumed.
module tb_umi_buffer;

  localparam int unsigned UW    = 256;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              nreset = 1'b1;
  logic              flush = 1'b0;
  logic              umi_in_valid = 1'b0;
  logic [UW-1:0]     umi_in_packet = '0;
  logic              umi_in_ready;
  logic              umi_out_valid;
  logic [UW-1:0]     umi_out_packet;
  logic              umi_out_ready = 1'b0;
  logic [AW:0]       fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  umi_buffer #(.UW(UW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .flush          (flush),
    .umi_in_valid   (umi_in_valid),
    .umi_in_packet  (umi_in_packet),
    .umi_in_ready   (umi_in_ready),
    .umi_out_valid  (umi_out_valid),
    .umi_out_packet (umi_out_packet),
    .umi_out_ready  (umi_out_ready),
    .fifo_count     (fifo_count),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty)
  );

  always #5 clk = ~clk;

`ifdef UMI_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [UW-1:0] q[$];
  logic          m_bypass;
  logic          m_out_valid;
  logic          m_in_ready;

  typedef struct {
    logic          v;
    logic [UW-1:0] pkt;
    logic          ordy;
    logic          fl;
    int unsigned   cnt;
    logic          rdy;
    logic          ov;
    logic          full;
    logic          empty;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [UW-1:0] act, input logic [UW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  // Drive inputs just after the edge, then compare settled outputs mid-cycle.
  task automatic drive(input logic v, input logic [UW-1:0] pkt, input logic ordy, input logic fl);
    logic [UW-1:0] exp_pkt;
    umi_in_valid  = v;
    umi_in_packet = pkt;
    umi_out_ready = ordy;
    flush         = fl;
    #4;
    if (!nreset) q.delete();
    m_in_ready  = (q.size() < DEPTH) && !fl;
    m_bypass    = BYP && (q.size() == 0) && !fl && v && nreset;
    m_out_valid = ((q.size() != 0) && !fl) || m_bypass;
    exp_pkt     = m_bypass ? pkt : (((q.size() != 0) && !fl) ? q[0] : '0);
    chk("out_valid",  UW'(umi_out_valid), UW'(m_out_valid));
    chk("out_packet", umi_out_packet, exp_pkt);
    chk("in_ready",   UW'(umi_in_ready), UW'(m_in_ready));
    chk("count",      UW'(fifo_count), UW'(q.size()));
    chk("full",       UW'(fifo_full), UW'(q.size() == DEPTH));
    chk("empty",      UW'(fifo_empty), UW'(q.size() == 0));
  endtask

  // Apply the model's view of this cycle's transfer, then cross the edge.
  task automatic advance();
    if (!nreset || flush) begin
      q.delete();
    end else if (!(m_bypass && umi_out_ready)) begin
      if (m_out_valid && umi_out_ready) void'(q.pop_front());
      if (umi_in_valid && m_in_ready) q.push_back(umi_in_packet);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic v, input logic [UW-1:0] pkt, input logic ordy, input logic fl);
    drive(v, pkt, ordy, fl);
    advance();
  endtask

  initial begin
    // Fill to full, hold a fifth packet, then drain in order.
    tbl[0]  = '{1'b1, UW'('hA1), 1'b0, 1'b0, 0, 1'b1, BYP,  1'b0, 1'b1};
    tbl[1]  = '{1'b1, UW'('hA2), 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, UW'('hA3), 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, UW'('hA4), 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, UW'('hA5), 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, UW'('hA5), 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, UW'('h00), 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, UW'('h00), 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, UW'('h00), 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, UW'('h00), 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, UW'('h00), 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset with a valid packet offered: nothing accepted, nothing shown.
    #1 nreset = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, UW'('hDEAD), 1'b1, 1'b0);
    cycle(1'b1, UW'('hDEAD), 1'b0, 1'b0);
    nreset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("rst_in_ready", UW'(umi_in_ready), UW'(1));
    chk("rst_count",    UW'(fifo_count), UW'(0));
    advance();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].pkt, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d_count", i), UW'(fifo_count),    UW'(tbl[i].cnt));
      chk($sformatf("tbl%0d_rdy", i),   UW'(umi_in_ready),  UW'(tbl[i].rdy));
      chk($sformatf("tbl%0d_ov", i),    UW'(umi_out_valid), UW'(tbl[i].ov));
      chk($sformatf("tbl%0d_full", i),  UW'(fifo_full),     UW'(tbl[i].full));
      chk($sformatf("tbl%0d_empty", i), UW'(fifo_empty),    UW'(tbl[i].empty));
      advance();
    end

    // Continuous streaming of 20 packets wraps the pointers several times.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, UW'(i), 1'b1, 1'b0);
      if (i == 0) chk("stream_first_ov", UW'(umi_out_valid), UW'(BYP));
      else        chk("stream_count", UW'(fifo_count), BYP ? UW'(0) : UW'(1));
      advance();
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drained", UW'(fifo_empty), UW'(1));

    // Simultaneous push and pop at count=2 keeps the count.
    cycle(1'b1, UW'('hC1), 1'b0, 1'b0);
    cycle(1'b1, UW'('hC2), 1'b0, 1'b0);
    cycle(1'b1, UW'('hC3), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("pushpop_count", UW'(fifo_count), UW'(2));
    advance();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush with 3 entries and a concurrent push discards everything.
    cycle(1'b1, UW'('hD1), 1'b0, 1'b0);
    cycle(1'b1, UW'('hD2), 1'b0, 1'b0);
    cycle(1'b1, UW'('hD3), 1'b0, 1'b0);
    drive(1'b1, UW'('hF0), 1'b1, 1'b1);
    chk("flush_ready", UW'(umi_in_ready), UW'(0));
    chk("flush_ov",    UW'(umi_out_valid), UW'(0));
    advance();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("post_flush_count", UW'(fifo_count), UW'(0));
    chk("post_flush_empty", UW'(fifo_empty), UW'(1));
    advance();
    cycle(1'b1, UW'('hB0), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-transfer loses stored contents.
    cycle(1'b1, UW'('hE1), 1'b0, 1'b0);
    cycle(1'b1, UW'('hE2), 1'b0, 1'b0);
    nreset = 1'b0;
    cycle(1'b1, UW'('hE3), 1'b1, 1'b0);
    nreset = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("midrst_count", UW'(fifo_count), UW'(0));
    advance();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
